// File: rtl/marble_launcher.sv
// marble_launcher: marble source and bottom-trigger controller for the tumble board.
// Launches one marble at a time (blue -> top-left, red -> top-right), waits for it to
// reach a bottom trigger, and lets the trigger side choose the next colour. Halts when
// the needed hopper is empty or when no trigger arrives within TIMEOUT flight cycles.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               begin a run (IDLE only)
//   i_reload              refill hoppers and clear flags (IDLE/HALT only)
//   i_trig_left/right     bottom trigger levels from the board
//   o_left, o_right       registered launch pulses (blue / red)
//   o_blue_cnt, o_red_cnt hopper contents
//   o_busy                high while launching or in flight
//   o_empty, o_timeout    sticky halt causes
//
// Optional feature (macro MARBLE_LAUNCHER_TRACE_EN):
//   o_launch_cnt  saturating launch count since reset/reload
//   o_last_side   colour of the most recent launch (0 blue, 1 red)
module marble_launcher #(
    parameter int unsigned BLUE_INIT  = 8,
    parameter int unsigned RED_INIT   = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned PULSE_LEN  = 2,
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          START_SIDE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_reload,
    input  logic             i_trig_left,
    input  logic             i_trig_right,
    output logic             o_left,
    output logic             o_right,
    output logic [CNT_W-1:0] o_blue_cnt,
    output logic [CNT_W-1:0] o_red_cnt,
    output logic             o_busy,
    output logic             o_empty,
    output logic             o_timeout
`ifdef MARBLE_LAUNCHER_TRACE_EN
    ,
    output logic [7:0]       o_launch_cnt,
    output logic             o_last_side
`endif
);

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam int unsigned PulseW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [CNT_W-1:0]  BlueInit  = CNT_W'(BLUE_INIT);
    localparam logic [CNT_W-1:0]  RedInit   = CNT_W'(RED_INIT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT);
    localparam logic [PulseW-1:0] PulseLast = PulseW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StFlight,
        StHalt
    } state_e;

    state_e              state_q, state_d;
    logic                side_q, side_d;          // 0 blue/left, 1 red/right
    logic [CNT_W-1:0]    blue_q, blue_d;
    logic [CNT_W-1:0]    red_q, red_d;
    logic [PulseW-1:0]   pulse_q, pulse_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                pend_q, pend_d;
    logic                pend_side_q, pend_side_d;
    logic                empty_q, empty_d;
    logic                tout_q, tout_d;
    logic                left_q, right_q;
    logic                trig_l_q, trig_l_prev_q;
    logic                trig_r_q, trig_r_prev_q;

    logic                edge_l, edge_r;
    logic                req, req_side, reload;

    assign edge_l = trig_l_q & ~trig_l_prev_q;
    assign edge_r = trig_r_q & ~trig_r_prev_q;

    always_comb begin
        state_d     = state_q;
        side_d      = side_q;
        blue_d      = blue_q;
        red_d       = red_q;
        pulse_d     = pulse_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        pend_side_d = pend_side_q;
        empty_d     = empty_q;
        tout_d      = tout_q;
        req         = 1'b0;
        req_side    = 1'b0;
        reload      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_reload) begin
                    reload = 1'b1;
                end else if (i_start) begin
                    req      = 1'b1;
                    req_side = START_SIDE;
                end
            end
            StLaunch: begin
                // Zero-delay boards can answer before the pulse ends; keep the first edge.
                if (!pend_q && (edge_l || edge_r)) begin
                    pend_d      = 1'b1;
                    pend_side_d = ~edge_l;
                end
                if (pulse_q == PulseLast) begin
                    state_d = StFlight;
                    timer_d = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            StFlight: begin
                if (pend_q) begin
                    req      = 1'b1;
                    req_side = pend_side_q;
                    pend_d   = 1'b0;
                end else if (edge_l || edge_r) begin
                    req      = 1'b1;
                    req_side = ~edge_l;
                end else if (timer_q == TimerLast) begin
                    state_d = StHalt;
                    tout_d  = 1'b1;
                    timer_d = TimerMax;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StHalt: begin
                if (i_reload) begin
                    reload  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reload) begin
            blue_d  = BlueInit;
            red_d   = RedInit;
            empty_d = 1'b0;
            tout_d  = 1'b0;
        end

        // Launch request: decrement only a non-empty hopper, otherwise halt.
        if (req) begin
            if (req_side ? (red_q != '0) : (blue_q != '0)) begin
                state_d = StLaunch;
                side_d  = req_side;
                pulse_d = '0;
                if (req_side) begin
                    red_d = red_q - 1'b1;
                end else begin
                    blue_d = blue_q - 1'b1;
                end
            end else begin
                state_d = StHalt;
                empty_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            side_q        <= 1'b0;
            blue_q        <= BlueInit;
            red_q         <= RedInit;
            pulse_q       <= '0;
            timer_q       <= '0;
            pend_q        <= 1'b0;
            pend_side_q   <= 1'b0;
            empty_q       <= 1'b0;
            tout_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            trig_l_q      <= 1'b0;
            trig_l_prev_q <= 1'b0;
            trig_r_q      <= 1'b0;
            trig_r_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            blue_q        <= blue_d;
            red_q         <= red_d;
            pulse_q       <= pulse_d;
            timer_q       <= timer_d;
            pend_q        <= pend_d;
            pend_side_q   <= pend_side_d;
            empty_q       <= empty_d;
            tout_q        <= tout_d;
            // Pulses follow the next state so they rise with the decrement edge.
            left_q        <= (state_d == StLaunch) & ~side_d;
            right_q       <= (state_d == StLaunch) & side_d;
            trig_l_q      <= i_trig_left;
            trig_l_prev_q <= trig_l_q;
            trig_r_q      <= i_trig_right;
            trig_r_prev_q <= trig_r_q;
        end
    end

    assign o_left     = left_q;
    assign o_right    = right_q;
    assign o_blue_cnt = blue_q;
    assign o_red_cnt  = red_q;
    assign o_busy     = (state_q == StLaunch) || (state_q == StFlight);
    assign o_empty    = empty_q;
    assign o_timeout  = tout_q;

`ifdef MARBLE_LAUNCHER_TRACE_EN
    logic [7:0] launch_cnt_q, launch_cnt_d;
    logic       last_side_q, last_side_d;
    logic       launch;

    // LAUNCH always exits to FLIGHT, so entering it marks exactly one launch.
    assign launch = (state_d == StLaunch) && (state_q != StLaunch);

    always_comb begin
        launch_cnt_d = launch_cnt_q;
        last_side_d  = last_side_q;
        if (reload) begin
            launch_cnt_d = '0;
            last_side_d  = 1'b0;
        end else if (launch) begin
            if (launch_cnt_q != 8'hFF) begin
                launch_cnt_d = launch_cnt_q + 8'd1;
            end
            last_side_d = side_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            launch_cnt_q <= '0;
            last_side_q  <= 1'b0;
        end else begin
            launch_cnt_q <= launch_cnt_d;
            last_side_q  <= last_side_d;
        end
    end

    assign o_launch_cnt = launch_cnt_q;
    assign o_last_side  = last_side_q;
`else
    // Default build carries no launch tracing state.
`endif

endmodule

// File: tb/tb_marble_launcher.sv
// Self-checking bench for marble_launcher (default parameters). Inputs change on the
// falling edge and outputs are sampled there. A transaction-level model tracks the two
// hoppers, the sticky flags and the launch trace; timing expectations come from the
// documented latencies (start -> pulse 1 cycle, trigger -> pulse 2 cycles).
module tb_marble_launcher;

    localparam int unsigned PulseLen = 2;
    localparam int unsigned Timeout  = 255;
    localparam int unsigned Init     = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       reload = 1'b0;
    logic       tl = 1'b0;
    logic       tr = 1'b0;
    logic       o_left, o_right, o_busy, o_empty, o_timeout;
    logic [3:0] blue_cnt, red_cnt;
`ifdef MARBLE_LAUNCHER_TRACE_EN
    logic [7:0] launch_cnt;
    logic       last_side;
`endif

    int n_checks = 0;
    int n_pass = 0;

    // Behavioural model: hopper contents indexed by colour (0 blue, 1 red).
    int hop[2];
    bit m_empty, m_tout;
    int m_launches;
    bit m_last;

    always #5 clk = ~clk;

    marble_launcher u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_reload    (reload),
        .i_trig_left (tl),
        .i_trig_right(tr),
        .o_left      (o_left),
        .o_right     (o_right),
        .o_blue_cnt  (blue_cnt),
        .o_red_cnt   (red_cnt),
        .o_busy      (o_busy),
        .o_empty     (o_empty),
        .o_timeout   (o_timeout)
`ifdef MARBLE_LAUNCHER_TRACE_EN
        ,
        .o_launch_cnt(launch_cnt),
        .o_last_side (last_side)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
            $error("check %s observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reload();
        hop[0] = Init;
        hop[1] = Init;
        m_empty = 1'b0;
        m_tout = 1'b0;
        m_launches = 0;
        m_last = 1'b0;
    endfunction

    // Returns 1 when a marble of colour s leaves its hopper, 0 when the run halts empty.
    function automatic bit model_request(input bit s);
        if (hop[s] > 0) begin
            hop[s]--;
            m_launches = (m_launches < 255) ? m_launches + 1 : 255;
            m_last = s;
            return 1'b1;
        end
        m_empty = 1'b1;
        return 1'b0;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_blue"}, blue_cnt, hop[0]);
        check({tag, "_red"}, red_cnt, hop[1]);
    endtask

    // Entered on the first pulse sample. Optionally raises triggers for one cycle
    // during the pulse; returns on the first flight sample.
    task automatic expect_pulse(input string tag, input bit s, input bit pl, input bit pr);
        for (int i = 0; i < PulseLen; i++) begin
            check({tag, "_pulse_left"}, o_left, (s == 1'b0));
            check({tag, "_pulse_right"}, o_right, (s == 1'b1));
            check({tag, "_pulse_busy"}, o_busy, 1);
            tl = (i == 0) ? pl : 1'b0;
            tr = (i == 0) ? pr : 1'b0;
            tick();
        end
        tl = 1'b0;
        tr = 1'b0;
        check({tag, "_after_left"}, o_left, 0);
        check({tag, "_after_right"}, o_right, 0);
        check({tag, "_after_busy"}, o_busy, 1);
        check_counts(tag);
    endtask

    // At the sample where a launch caused by side (l,r) should be visible.
    task automatic resolve(input string tag, input bit l, input bit r, input bit pl,
                           input bit pr, output bit halted);
        bit cl, nl, nr, done;
        cl = l;
        nl = pl;
        nr = pr;
        halted = 1'b0;
        done = 1'b0;
        while (!done) begin
            if (model_request(cl ? 1'b0 : 1'b1)) begin
                expect_pulse(tag, cl ? 1'b0 : 1'b1, nl, nr);
                if (nl || nr) begin
                    // Pending edge: next launch follows one flight cycle later.
                    tick();
                    cl = nl;
                    nl = 1'b0;
                    nr = 1'b0;
                end else begin
                    done = 1'b1;
                end
            end else begin
                check({tag, "_halt_left"}, o_left, 0);
                check({tag, "_halt_right"}, o_right, 0);
                check({tag, "_halt_busy"}, o_busy, 0);
                check({tag, "_halt_empty"}, o_empty, 1);
                check({tag, "_halt_timeout"}, o_timeout, 0);
                check_counts({tag, "_halt"});
                halted = 1'b1;
                done = 1'b1;
            end
        end
        if (r && !l) begin
            // right-only request already handled through cl
        end
    endtask

    task automatic fire(input string tag, input bit l, input bit r, input bit pl,
                        input bit pr, output bit halted);
        tl = l;
        tr = r;
        tick();
        tl = 1'b0;
        tr = 1'b0;
        tick();
        resolve(tag, l, r, pl, pr, halted);
    endtask

    // From the first flight sample, wait k cycles then raise the left trigger.
    task automatic late_fire(input string tag, input int k);
        bit h;
        for (int j = 0; j < k; j++) tick();
        tl = 1'b1;
        tick();
        tl = 1'b0;
        tick();
        if (k + 2 <= Timeout) begin
            resolve(tag, 1'b1, 1'b0, 1'b0, 1'b0, h);
        end else begin
            m_tout = 1'b1;
            check({tag, "_late_busy"}, o_busy, 0);
            check({tag, "_late_left"}, o_left, 0);
            check({tag, "_late_timeout"}, o_timeout, m_tout);
            check({tag, "_late_empty"}, o_empty, m_empty);
            check_counts({tag, "_late"});
        end
    endtask

    task automatic restart(input string tag);
        bit h;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        model_reload();
        check_counts({tag, "_reload"});
        check({tag, "_reload_empty"}, o_empty, 0);
        check({tag, "_reload_timeout"}, o_timeout, 0);
        check({tag, "_reload_busy"}, o_busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        resolve({tag, "_start"}, 1'b1, 1'b0, 1'b0, 1'b0, h);
    endtask

    initial begin
        bit h;
        int cycles;

        // Reset state
        repeat (3) tick();
        model_reload();
        check("rst_left", o_left, 0);
        check("rst_right", o_right, 0);
        check("rst_busy", o_busy, 0);
        check("rst_empty", o_empty, 0);
        check("rst_timeout", o_timeout, 0);
        check_counts("rst");
`ifdef MARBLE_LAUNCHER_TRACE_EN
        check("rst_launch_cnt", launch_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Start: blue pulse for PulseLen cycles, blue 8 -> 7
        start = 1'b1;
        tick();
        start = 1'b0;
        resolve("start", 1'b1, 1'b0, 1'b0, 1'b0, h);

        fire("trig_right", 1'b0, 1'b1, 1'b0, 1'b0, h);
        fire("trig_left", 1'b1, 1'b0, 1'b0, 1'b0, h);
        fire("trig_both", 1'b1, 1'b1, 1'b0, 1'b0, h);
        // Right trigger, then a left edge arrives during the red pulse.
        fire("pending", 1'b0, 1'b1, 1'b1, 1'b0, h);

        // Edge landing on the last flight cycle beats the timeout.
        late_fire("edge_at_limit", Timeout - 2);

        // Silent flight: exactly Timeout flight cycles, then halt.
        cycles = 0;
        while (o_busy === 1'b1 && cycles < 400) begin
            tick();
            cycles++;
        end
        m_tout = 1'b1;
        check("timeout_cycles", cycles, Timeout);
        check("timeout_flag", o_timeout, 1);
        check("timeout_empty", o_empty, 0);
        check_counts("timeout");

        // i_start ignored in HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("halt_start_busy", o_busy, 0);
        check("halt_start_left", o_left, 0);
        check("halt_start_flag", o_timeout, 1);
        check_counts("halt_start");

        restart("after_timeout");
        late_fire("edge_after_limit", Timeout - 1);

        // Drain blue: start takes one, then seven lefts, then the next left halts.
        restart("drain");
        for (int i = 0; i < Init - 1; i++) fire("drain_left", 1'b1, 1'b0, 1'b0, 1'b0, h);
        fire("drain_last", 1'b1, 1'b0, 1'b0, 1'b0, h);
        check("drain_halted", h, 1);
        tick();
        check("drain_no_pulse", o_left, 0);
        check("drain_empty_sticky", o_empty, 1);

        // Randomized runs against the model
        restart("rand_begin");
        for (int it = 0; it < 48; it++) begin
            int d, pat, ppat;
            bit l, r, pl, pr;
            d = $urandom_range(0, 4);
            pat = $urandom_range(1, 3);
            ppat = $urandom_range(0, 5);
            l = (pat & 1) != 0;
            r = (pat & 2) != 0;
            pl = (ppat == 1) || (ppat == 3);
            pr = (ppat == 2) || (ppat == 3);
            for (int j = 0; j < d; j++) begin
                check("rand_wait_busy", o_busy, 1);
                tick();
            end
            fire("rand", l, r, pl, pr, h);
            if (h) restart("rand_restart");
        end
`ifdef MARBLE_LAUNCHER_TRACE_EN
        check("trace_launch_cnt", launch_cnt, m_launches);
        check("trace_last_side", last_side, m_last);
`endif

        // Reset in the middle of a launch pulse
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reload();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst_pulse_before", o_left, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_left", o_left, 0);
        check("midrst_right", o_right, 0);
        check("midrst_busy", o_busy, 0);
        check_counts("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_idle_busy", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
